// File: rtl/mem_packet_responder.sv
// mem_packet_responder: ring node that serves WR1/WR4/RD4 packets against a local byte memory over 4-phase handshakes.
// Ports: clk, rst_n (async, active-low); in_req/in_data/in_ack receive a request packet;
//        out_req/out_data/out_ack return an RD4 response; busy is high outside IDLE;
//        drop_cnt saturates at 255 and counts misaddressed or reserved-type packets.
module mem_packet_responder #(
  parameter int DWIDTH = 8,
  parameter int PWIDTH = 47,
  parameter int DEPTH = 64,
  parameter logic [2:0] MEM_ID = 3'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_req,
  input  logic [PWIDTH-1:0] in_data,
  output logic              in_ack,
  output logic              out_req,
  output logic [PWIDTH-1:0] out_data,
  input  logic              out_ack,
  output logic              busy,
  output logic [7:0]        drop_cnt
);
  typedef enum logic [2:0] {IDLE, ACK, EXEC, SEND, SEND_RTZ} state_t;
  state_t              r_state;
  logic [PWIDTH-1:0]   r_pkt;
  logic [1:0]          r_idx;
  logic [23:0]         r_rd;
  logic [DWIDTH-1:0]   r_mem [DEPTH];
  logic                r_in_ack;
  logic                r_out_req;
  logic [PWIDTH-1:0]   r_out_data;
  logic                r_busy;
  logic [7:0]          r_drop_cnt;
  logic [2:0]          w_dest;
  logic [1:0]          w_type;
  logic [5:0]          w_a;
  logic [7:0]          w_wbyte;
  logic [7:0]          w_byte;
  logic                w_drop;
  assign w_dest  = r_pkt[43:41];
  assign w_type  = r_pkt[40:39];
  // 6-bit add wraps addr+i modulo 64
  assign w_a     = r_pkt[38:33] + {4'd0, r_idx};
  // r_idx is 0 for WR1, so the same select yields data[7:0]
  assign w_wbyte = r_pkt[{r_idx, 3'b000} +: 8];
  assign w_byte  = 8'(r_mem[w_a]);
  assign w_drop  = (w_dest != MEM_ID) || (w_type == 2'b11);
  assign in_ack   = r_in_ack;
  assign out_req  = r_out_req;
  assign out_data = r_out_data;
  assign busy     = r_busy;
  assign drop_cnt = r_drop_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pkt      <= '0;
      r_idx      <= '0;
      r_rd       <= '0;
      r_in_ack   <= 1'b0;
      r_out_req  <= 1'b0;
      r_out_data <= '0;
      r_busy     <= 1'b0;
      r_drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_req) begin
          // reserved bit 32 is cleared on capture so the response carries 0 there
          r_pkt    <= in_data & ~(PWIDTH'(1) << 32);
          r_in_ack <= 1'b1;
          r_busy   <= 1'b1;
          r_state  <= ACK;
        end
        ACK: if (!in_req) begin
          r_in_ack <= 1'b0;
          r_idx    <= '0;
          if (w_drop) begin
            r_drop_cnt <= r_drop_cnt + {7'd0, ~&r_drop_cnt};
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else r_state <= EXEC;
        end
        EXEC: begin
          r_idx <= r_idx + 2'd1;
          if (w_type == 2'b10) r_rd <= {w_byte, r_rd[23:8]};
          else r_mem[w_a] <= DWIDTH'(w_wbyte);
          if (w_type == 2'b00 || r_idx == 2'd3) begin
            if (w_type == 2'b10) begin
              r_out_req  <= 1'b1;
              r_out_data <= PWIDTH'({MEM_ID, r_pkt[46:44], 2'b10, r_pkt[38:32], w_byte, r_rd});
              r_state    <= SEND;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        SEND: if (out_ack) begin
          r_out_req <= 1'b0;
          r_state   <= SEND_RTZ;
        end
        SEND_RTZ: if (!out_ack) begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_packet_responder.sv
// tb_mem_packet_responder: vector table, corner sequences and randomized traffic against a packet-level memory model.
module tb_mem_packet_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_req = 1'b0;
  logic [46:0] in_data = '0;
  logic        in_ack;
  logic        out_req;
  logic [46:0] out_data;
  logic        out_ack = 1'b0;
  logic        busy;
  logic [7:0]  drop_cnt;
  int          n_pass = 0;
  int          n_total = 0;
  logic [7:0]  mem_m [64];
  int          drop_m = 0;
  mem_packet_responder dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack), .busy(busy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [46:0] pkt;
    logic        resp;
    logic [31:0] data;
    logic [7:0]  drop;
  } vec_t;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask
  function automatic logic [46:0] mk(input logic [2:0] s, input logic [2:0] d, input logic [1:0] t,
                                     input logic [5:0] a, input logic [31:0] w);
    return {s, d, t, a, 1'b0, w};
  endfunction
  function automatic void model_clear();
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
    drop_m = 0;
  endfunction
  function automatic void model_apply(input logic [46:0] p, output logic r, output logic [31:0] d);
    int t = int'(p[40:39]);
    int a = int'(p[38:33]);
    r = 1'b0;
    d = '0;
    if (p[43:41] != 3'd0 || t == 3) drop_m = (drop_m < 255) ? drop_m + 1 : 255;
    else if (t == 0) mem_m[a] = p[7:0];
    else if (t == 1) for (int i = 0; i < 4; i++) mem_m[(a + i) % 64] = p[8*i +: 8];
    else begin
      r = 1'b1;
      for (int i = 0; i < 4; i++) d[8*i +: 8] = mem_m[(a + i) % 64];
    end
  endfunction
  task automatic xact(input logic [46:0] p, output logic got_resp, output logic [31:0] got_data);
    int n = 0;
    got_resp = 1'b0;
    got_data = '0;
    in_data = p;
    in_req = 1'b1;
    tick();
    chk("ack_rise", 64'(in_ack), 64'd1);
    in_req = 1'b0;
    tick();
    chk("ack_fall", 64'(in_ack), 64'd0);
    while (!out_req && busy && n < 12) begin
      tick();
      n++;
    end
    if (out_req) begin
      got_resp = 1'b1;
      chk("rd_latency", 64'(n), 64'd4);
      chk("rsp_header", 64'(out_data[46:32]), 64'({3'd0, p[46:44], 2'b10, p[38:33], 1'b0}));
      got_data = out_data[31:0];
      out_ack = 1'b1;
      tick();
      chk("out_req_rtz", 64'(out_req), 64'd0);
      out_ack = 1'b0;
      tick();
    end
    chk("back_idle", 64'(busy), 64'd0);
  endtask
  initial begin
    vec_t        tbl [10];
    logic        r, er;
    logic [31:0] d, ed;
    logic [46:0] p1, p2, d0;
    int          n;
    tbl[0] = '{mk(3'd2, 3'd0, 2'b00, 6'd5,  32'h000000A7), 1'b0, 32'h0,        8'd0};
    tbl[1] = '{mk(3'd3, 3'd0, 2'b10, 6'd5,  32'h0),        1'b1, 32'h000000A7, 8'd0};
    tbl[2] = '{mk(3'd1, 3'd0, 2'b01, 6'd62, 32'h44332211), 1'b0, 32'h0,        8'd0};
    tbl[3] = '{mk(3'd1, 3'd0, 2'b10, 6'd62, 32'h0),        1'b1, 32'h44332211, 8'd0};
    tbl[4] = '{mk(3'd4, 3'd0, 2'b10, 6'd63, 32'h0),        1'b1, 32'h00443322, 8'd0};
    tbl[5] = '{mk(3'd2, 3'd3, 2'b00, 6'd5,  32'h000000FF), 1'b0, 32'h0,        8'd1};
    tbl[6] = '{mk(3'd2, 3'd0, 2'b11, 6'd5,  32'h000000FF), 1'b0, 32'h0,        8'd2};
    tbl[7] = '{mk(3'd6, 3'd0, 2'b10, 6'd4,  32'h0),        1'b1, 32'h0000A700, 8'd2};
    tbl[8] = '{mk(3'd7, 3'd0, 2'b00, 6'd0,  32'hDEADBE5A), 1'b0, 32'h0,        8'd2};
    tbl[9] = '{mk(3'd5, 3'd0, 2'b10, 6'd63, 32'h0),        1'b1, 32'h00445A22, 8'd2};
    model_clear();
    #12;
    chk("rst_in_ack", 64'(in_ack), 64'd0);
    chk("rst_out_req", 64'(out_req), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      model_apply(tbl[i].pkt, er, ed);
      xact(tbl[i].pkt, r, d);
      chk($sformatf("vec%0d_resp", i), 64'(r), 64'(tbl[i].resp));
      chk($sformatf("vec%0d_data", i), 64'(d), 64'(tbl[i].data));
      chk($sformatf("vec%0d_drop", i), 64'(drop_cnt), 64'(tbl[i].drop));
    end
    p1 = mk(3'd5, 3'd0, 2'b10, 6'd62, 32'h0);
    p2 = mk(3'd2, 3'd0, 2'b00, 6'd10, 32'h0000003C);
    model_apply(p1, er, ed);
    in_data = p1;
    in_req = 1'b1;
    tick();
    in_req = 1'b0;
    tick();
    n = 0;
    while (!out_req && n < 12) begin
      tick();
      n++;
    end
    chk("bp_latency", 64'(n), 64'd4);
    chk("bp_data", 64'(out_data[31:0]), 64'(ed));
    d0 = out_data;
    in_data = p2;
    in_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_hold", 64'({out_req, in_ack, out_data}), 64'({1'b1, 1'b0, d0}));
    end
    out_ack = 1'b1;
    tick();
    chk("bp_rtz_req", 64'({out_req, in_ack}), 64'd0);
    out_ack = 1'b0;
    tick();
    chk("bp_rtz_noack", 64'(in_ack), 64'd0);
    tick();
    chk("bp_second_ack", 64'(in_ack), 64'd1);
    in_req = 1'b0;
    n = 0;
    while ((in_ack || busy) && n < 12) begin
      tick();
      n++;
    end
    chk("bp_second_done", 64'(busy), 64'd0);
    model_apply(p2, er, ed);
    for (int i = 0; i < 60; i++) begin
      logic [46:0] p = {3'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0,
                        2'($urandom), 6'($urandom), 1'($urandom), $urandom};
      model_apply(p, er, ed);
      xact(p, r, d);
      chk("rnd_resp", 64'(r), 64'(er));
      chk("rnd_data", 64'(d), 64'(ed));
      chk("rnd_drop", 64'(drop_cnt), 64'(drop_m));
    end
    for (int i = 0; i < 300; i++) begin
      model_apply(mk(3'd1, 3'd3, 2'b00, 6'd1, 32'h1), er, ed);
      xact(mk(3'd1, 3'd3, 2'b00, 6'd1, 32'h1), r, d);
    end
    chk("drop_sat", 64'(drop_cnt), 64'd255);
    model_apply(mk(3'd0, 3'd0, 2'b10, 6'd10, 32'h0), er, ed);
    xact(mk(3'd0, 3'd0, 2'b10, 6'd10, 32'h0), r, d);
    chk("post_drop_mem", 64'(d), 64'(ed));
    in_data = mk(3'd3, 3'd0, 2'b01, 6'd20, 32'hAABBCCDD);
    in_req = 1'b1;
    tick();
    in_req = 1'b0;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("mid_rst_outs", 64'({in_ack, out_req, out_data, busy, drop_cnt}), 64'd0);
    in_data = mk(3'd2, 3'd0, 2'b00, 6'd7, 32'h99);
    in_req = 1'b1;
    #3 rst_n = 1'b1;
    tick();
    chk("req_at_release", 64'(in_ack), 64'd1);
    in_req = 1'b0;
    n = 0;
    while ((in_ack || busy) && n < 12) begin
      tick();
      n++;
    end
    chk("release_done", 64'(busy), 64'd0);
    model_apply(mk(3'd2, 3'd0, 2'b00, 6'd7, 32'h99), er, ed);
    for (int i = 0; i < 3; i++) begin
      logic [46:0] p = mk(3'd1, 3'd0, 2'b10, (i == 0) ? 6'd20 : (i == 1) ? 6'd62 : 6'd6, 32'h0);
      model_apply(p, er, ed);
      xact(p, r, d);
      chk("post_rst_read", 64'(d), 64'(ed));
    end
    chk("post_rst_drop", 64'(drop_cnt), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_packet_responder.md
MEM_PACKET_RESPONDER -- requirements
Module: mem_packet_responder

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, meaning the memory word width in bits.
REQ-002 SHALL have parameter PWIDTH, default 47, meaning the packet width in bits.
REQ-003 SHALL have parameter DEPTH, default 64, meaning the number of words; the address is 6 bits.
REQ-004 SHALL have parameter MEM_ID, default 3'd0, meaning this node's ring address.
REQ-005 SHALL have one clock and one reset, as decided: clk  input  1  single clock; rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_req  input  1  4-phase request from the ring; a packet is pending.
REQ-007 SHALL have port in_data  input  PWIDTH  bundled request packet; valid while in_req is high.
REQ-008 SHALL have port in_ack  output  1  4-phase acknowledge to the ring.
REQ-009 SHALL have port out_req  output  1  4-phase request to the ring; a response is pending.
REQ-010 SHALL have port out_data  output  PWIDTH  bundled response packet.
REQ-011 SHALL have port out_ack  input  1  4-phase acknowledge from the ring.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port drop_cnt  output  8  saturating count of discarded packets.

Function
REQ-014 SHALL decode the packet fields as follows: [46:44] src, [43:41] dest, [40:39] type, [38:33] addr, [31:0] data; bit [32] is reserved, ignored on input and driven 0 on output.
REQ-015 SHALL support these type codes: 00 WR1 (write data[7:0] to addr), 01 WR4 (write byte i of data to addr+i, i=0..3), 10 RD4 (read addr..addr+3), 11 reserved.
REQ-016 SHALL compute every address addr+i modulo DEPTH, so addresses wrap from 63 to 0.
REQ-017 SHALL use the FSM states IDLE, ACK, EXEC, SEND and SEND_RTZ.
REQ-018 SHALL, in IDLE when in_req is sampled high, latch in_data, set in_ack=1 on the next edge and enter ACK.
REQ-019 SHALL, in ACK, hold in_ack=1 until in_req is sampled low, then set in_ack=0 and enter EXEC.
REQ-020 SHALL, in EXEC, perform WR1 in 1 cycle, WR4 as 4 cycles of one byte each, and RD4 as 4 cycles of one byte each into a response register.
REQ-021 SHALL, after WR1 or WR4, return to IDLE without producing a response.
REQ-022 SHALL, after RD4, enter SEND with out_data = {src=MEM_ID, dest=latched src, type=10, addr=latched addr, bit32=0, data={mem[a+3],mem[a+2],mem[a+1],mem[a]}}.
REQ-023 SHALL, in SEND, set out_req=1 and hold out_data stable until out_ack is sampled high, then enter SEND_RTZ.
REQ-024 SHALL, in SEND_RTZ, set out_req=0 and return to IDLE once out_ack is sampled low.
REQ-025 SHALL handle one transaction at a time: in_ack stays 0 outside IDLE and ACK, so the ring is back-pressured.
REQ-026 SHALL, when dest != MEM_ID or type = 11, complete the input handshake normally, skip EXEC, increment drop_cnt (saturating at 255) and return to IDLE.
REQ-027 SHALL make a write that completes before a later RD4 is accepted visible to that RD4, including overlapping and wrapped addresses.
REQ-028 SHALL ignore out_ack while not in SEND or SEND_RTZ.
REQ-029 SHALL give an RD4 a latency of exactly 4 cycles from in_ack falling to out_req rising.
REQ-030 SHALL drive all outputs from registers only.

Reset
REQ-031 SHALL, while rst_n=0 and independent of clk, force in_ack=0, out_req=0, out_data=0, busy=0, drop_cnt=0, every memory word to 0 and the FSM to IDLE.
REQ-032 SHALL, on reset asserted mid-transaction, abandon the transaction with no partial writes after assertion and no response.
REQ-033 SHALL, if in_req is high at reset release, treat it as a new request on the first active edge.

Verification
REQ-034 SHALL cover WR1: in_data {src=2,dest=0,type=00,addr=5,data=0xA7} -> in_ack high 1 cycle after in_req, mem[5]=0xA7, no out_req.
REQ-035 SHALL cover WR4 with wrap: {src=1,type=01,addr=62,data=0x44332211} -> mem[62]=0x11, mem[63]=0x22, mem[0]=0x33, mem[1]=0x44.
REQ-036 SHALL cover RD4 after that write: {src=1,type=10,addr=62} -> out_data dest=1, src=0, type=10, addr=62, data=0x44332211; out_req rises 4 cycles after in_ack falls.
REQ-037 SHALL cover back-pressure: out_ack held low for 20 cycles with a second in_req pending -> out_data stable and in_ack=0 throughout; the second request is accepted only after SEND_RTZ completes.
REQ-038 SHALL cover drops: dest=3, then type=11 -> drop_cnt=2, memory unchanged, no out_req; 300 dropped packets -> drop_cnt=255.
REQ-039 SHALL cover reset during WR4 EXEC: assert rst_n low after 2 bytes -> all outputs 0 and all memory 0 immediately; the next RD4 returns data=0.
